// File: rtl/axi_stream_insert_arbiter.sv
// Round-robin arbiter that shares one insert-header engine between NUM_SRC requesters.
// state | meaning:  IDLE = arbitrate | HDR = forward granted header | DATA = forward granted payload
module axi_stream_insert_arbiter #(
    parameter int NUM_SRC      = 4,
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int ID_WD        = $clog2(NUM_SRC)
) (
    input  logic                              clk,
    input  logic                              rst,

    input  logic [NUM_SRC-1:0]                s_valid_insert,
    input  logic [NUM_SRC*DATA_WD-1:0]        s_header_insert,
    input  logic [NUM_SRC*DATA_BYTE_WD-1:0]   s_keep_insert,
    output logic [NUM_SRC-1:0]                s_ready_insert,

    input  logic [NUM_SRC-1:0]                s_valid_in,
    input  logic [NUM_SRC*DATA_WD-1:0]        s_data_in,
    input  logic [NUM_SRC*DATA_BYTE_WD-1:0]   s_keep_in,
    input  logic [NUM_SRC-1:0]                s_last_in,
    output logic [NUM_SRC-1:0]                s_ready_in,

    output logic                              valid_insert,
    output logic [DATA_WD-1:0]                header_insert,
    output logic [DATA_BYTE_WD-1:0]           keep_insert,
    input  logic                              ready_insert,

    output logic                              valid_in,
    output logic [DATA_WD-1:0]                data_in,
    output logic [DATA_BYTE_WD-1:0]           keep_in,
    output logic                              last_in,
    input  logic                              ready_in,

    output logic [ID_WD-1:0]                  grant_id,
    output logic                              busy,
    output logic [15:0]                       pkt_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ID_WD-1:0]        r_grant_id;
    logic [ID_WD-1:0]        r_last_grant;
    logic [15:0]             r_pkt_cnt;

    logic                    w_found;
    logic [ID_WD-1:0]        w_winner;
    logic                    w_pkt_done;

    logic                    w_sel_vins;
    logic [DATA_WD-1:0]      w_sel_hdr;
    logic [DATA_BYTE_WD-1:0] w_sel_hkeep;
    logic                    w_sel_vin;
    logic [DATA_WD-1:0]      w_sel_data;
    logic [DATA_BYTE_WD-1:0] w_sel_dkeep;
    logic                    w_sel_last;

    // Search upward from the source after the last one served, so it ends up with lowest priority.
    always_comb begin : rr_search
        logic [ID_WD-1:0] v_idx;
        w_found  = 1'b0;
        w_winner = '0;
        v_idx    = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            v_idx = ID_WD'((int'(r_last_grant) + k) % NUM_SRC);
            if (!w_found && s_valid_insert[v_idx]) begin
                w_found  = 1'b1;
                w_winner = v_idx;
            end
        end
    end

    always_comb begin : grant_mux
        w_sel_vins  = 1'b0;
        w_sel_hdr   = '0;
        w_sel_hkeep = '0;
        w_sel_vin   = 1'b0;
        w_sel_data  = '0;
        w_sel_dkeep = '0;
        w_sel_last  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_grant_id == ID_WD'(i)) begin
                w_sel_vins  = s_valid_insert[i];
                w_sel_hdr   = s_header_insert[i*DATA_WD +: DATA_WD];
                w_sel_hkeep = s_keep_insert[i*DATA_BYTE_WD +: DATA_BYTE_WD];
                w_sel_vin   = s_valid_in[i];
                w_sel_data  = s_data_in[i*DATA_WD +: DATA_WD];
                w_sel_dkeep = s_keep_in[i*DATA_BYTE_WD +: DATA_BYTE_WD];
                w_sel_last  = s_last_in[i];
            end
        end
    end

    always_comb begin : fsm_comb
        w_state_nxt    = r_state;
        w_pkt_done     = 1'b0;
        valid_insert   = 1'b0;
        header_insert  = '0;
        keep_insert    = '0;
        s_ready_insert = '0;
        valid_in       = 1'b0;
        data_in        = '0;
        keep_in        = '0;
        last_in        = 1'b0;
        s_ready_in     = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                valid_insert               = w_sel_vins;
                header_insert              = w_sel_hdr;
                keep_insert                = w_sel_hkeep;
                s_ready_insert[r_grant_id] = ready_insert;
                if (w_sel_vins && ready_insert) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                valid_in               = w_sel_vin;
                data_in                = w_sel_data;
                keep_in                = w_sel_dkeep;
                last_in                = w_sel_last;
                s_ready_in[r_grant_id] = ready_in;
                if (w_sel_vin && ready_in && w_sel_last) begin
                    w_pkt_done  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_grant_id   <= '0;
            r_last_grant <= ID_WD'(NUM_SRC - 1);
            r_pkt_cnt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_found) begin
                r_grant_id <= w_winner;
            end
            if (w_pkt_done) begin
                r_last_grant <= r_grant_id;
                r_pkt_cnt    <= r_pkt_cnt + 16'd1;
            end
        end
    end

    assign grant_id = r_grant_id;
    assign busy     = (r_state != ST_IDLE);
    assign pkt_cnt  = r_pkt_cnt;

endmodule

// File: tb/tb_axi_stream_insert_arbiter.sv
// Randomized scoreboard bench for axi_stream_insert_arbiter: per-source drivers, a
// behavioural round-robin model and a negedge monitor that checks every engine-side cycle.
module tb_axi_stream_insert_arbiter;

    localparam int NSRC = 4;
    localparam int DW   = 32;
    localparam int KW   = DW / 8;
    localparam int IDW  = 2;

    typedef struct packed {
        logic [DW-1:0] h;
        logic [KW-1:0] k;
    } hdr_t;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NSRC-1:0]      s_valid_insert;
    logic [NSRC*DW-1:0]   s_header_insert;
    logic [NSRC*KW-1:0]   s_keep_insert;
    logic [NSRC-1:0]      s_ready_insert;
    logic [NSRC-1:0]      s_valid_in;
    logic [NSRC*DW-1:0]   s_data_in;
    logic [NSRC*KW-1:0]   s_keep_in;
    logic [NSRC-1:0]      s_last_in;
    logic [NSRC-1:0]      s_ready_in;
    logic                 valid_insert;
    logic [DW-1:0]        header_insert;
    logic [KW-1:0]        keep_insert;
    logic                 ready_insert;
    logic                 valid_in;
    logic [DW-1:0]        data_in;
    logic [KW-1:0]        keep_in;
    logic                 last_in;
    logic                 ready_in;
    logic [IDW-1:0]       grant_id;
    logic                 busy;
    logic [15:0]          pkt_cnt;

    axi_stream_insert_arbiter #(
        .NUM_SRC(NSRC), .DATA_WD(DW), .DATA_BYTE_WD(KW), .ID_WD(IDW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid_insert(s_valid_insert), .s_header_insert(s_header_insert),
        .s_keep_insert(s_keep_insert), .s_ready_insert(s_ready_insert),
        .s_valid_in(s_valid_in), .s_data_in(s_data_in), .s_keep_in(s_keep_in),
        .s_last_in(s_last_in), .s_ready_in(s_ready_in),
        .valid_insert(valid_insert), .header_insert(header_insert),
        .keep_insert(keep_insert), .ready_insert(ready_insert),
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in),
        .last_in(last_in), .ready_in(ready_in),
        .grant_id(grant_id), .busy(busy), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    // stimulus queues (driver side) and scoreboard queues (monitor side)
    hdr_t  src_hdr [NSRC][$];
    beat_t src_beat[NSRC][$];
    hdr_t  exp_hdr [NSRC][$];
    beat_t exp_beat[NSRC][$];
    int    grant_log[$];

    int n_checks = 0;
    int n_err    = 0;
    int rdy_pct  = 100;
    int rst_req_cnt = 0, rst_ack_cnt = 0;
    int bp_req_cnt  = 0, bp_ack_cnt  = 0;

    // reference model state
    int          cur_src = -1;
    bit          in_data = 1'b0;
    bit          hdr_first = 1'b0;
    int          last_grant = NSRC - 1;
    logic [15:0] mdl_cnt = '0;
    int          cur_beats = 0;
    int          total_beats = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [NSRC-1:0] req);
        for (int k = 1; k <= NSRC; k++) begin
            if (req[(last + k) % NSRC]) return (last + k) % NSRC;
        end
        return -1;
    endfunction

    task automatic issue_pkt(input int s, input logic [DW-1:0] h, input logic [KW-1:0] k, input int nb);
        hdr_t  hv;
        beat_t bv;
        hv.h = h;
        hv.k = k;
        src_hdr[s].push_back(hv);
        exp_hdr[s].push_back(hv);
        for (int b = 0; b < nb; b++) begin
            bv.d = $urandom;
            bv.k = KW'($urandom);
            bv.l = (b == nb - 1);
            src_beat[s].push_back(bv);
            exp_beat[s].push_back(bv);
        end
    endtask

    // Sources and engine readiness. Handshakes are sampled at negedge, queues advance after posedge.
    initial begin : driver
        logic [NSRC-1:0] hs_ins, hs_in;
        beat_t           dummy_b;
        hdr_t            dummy_h;
        int              bp_left;
        bp_left = 0;
        rst = 1'b1;
        s_valid_insert = '0; s_header_insert = '0; s_keep_insert = '0;
        s_valid_in = '0; s_data_in = '0; s_keep_in = '0; s_last_in = '0;
        ready_insert = 1'b0; ready_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        forever begin
            @(negedge clk);
            hs_ins = s_valid_insert & s_ready_insert;
            hs_in  = s_valid_in & s_ready_in;
            @(posedge clk);
            #1;
            if (rst_req_cnt != rst_ack_cnt) begin
                rst_ack_cnt = rst_req_cnt;
                rst = 1'b1;
                for (int i = 0; i < NSRC; i++) begin
                    src_hdr[i].delete();
                    src_beat[i].delete();
                end
                s_valid_insert = '0;
                s_valid_in     = '0;
                ready_insert   = 1'b0;
                ready_in       = 1'b0;
            end else begin
                rst = 1'b0;
                for (int i = 0; i < NSRC; i++) begin
                    if (hs_ins[i] && src_hdr[i].size() > 0) dummy_h = src_hdr[i].pop_front();
                    if (hs_in[i] && src_beat[i].size() > 0) dummy_b = src_beat[i].pop_front();
                    if (src_hdr[i].size() > 0) begin
                        s_valid_insert[i]          = 1'b1;
                        s_header_insert[i*DW +: DW] = src_hdr[i][0].h;
                        s_keep_insert[i*KW +: KW]   = src_hdr[i][0].k;
                    end else begin
                        s_valid_insert[i]          = 1'b0;
                        s_header_insert[i*DW +: DW] = $urandom;
                        s_keep_insert[i*KW +: KW]   = KW'($urandom);
                    end
                    // a stalled valid beat must stay up; otherwise valid is randomly gapped
                    if (src_beat[i].size() == 0) s_valid_in[i] = 1'b0;
                    else if (!(s_valid_in[i] && !hs_in[i])) s_valid_in[i] = (($urandom % 4) != 0);
                    if (s_valid_in[i]) begin
                        s_data_in[i*DW +: DW] = src_beat[i][0].d;
                        s_keep_in[i*KW +: KW] = src_beat[i][0].k;
                        s_last_in[i]          = src_beat[i][0].l;
                    end else begin
                        s_data_in[i*DW +: DW] = $urandom;
                        s_keep_in[i*KW +: KW] = KW'($urandom);
                        s_last_in[i]          = 1'($urandom);
                    end
                end
                if (bp_req_cnt != bp_ack_cnt) begin
                    bp_ack_cnt = bp_req_cnt;
                    bp_left    = 3;
                end
                ready_insert = ($urandom_range(0, 99) < rdy_pct);
                if (bp_left > 0) begin
                    ready_in = 1'b0;
                    bp_left--;
                end else begin
                    ready_in = ($urandom_range(0, 99) < rdy_pct);
                end
            end
        end
    end

    // Monitor + reference model: compares all engine-facing outputs every cycle.
    initial begin : monitor
        logic [NSRC-1:0] ev;
        logic [IDW-1:0]  g;
        beat_t           eb;
        hdr_t            eh;
        forever begin
            @(negedge clk);
            if (rst) begin
                cur_src = -1; in_data = 1'b0; last_grant = NSRC - 1; mdl_cnt = '0;
                for (int i = 0; i < NSRC; i++) begin
                    exp_hdr[i].delete();
                    exp_beat[i].delete();
                end
                continue;
            end
            chk("busy", 64'(busy), 64'(cur_src >= 0));
            chk("pkt_cnt", 64'(pkt_cnt), 64'(mdl_cnt));
            if (cur_src < 0) begin
                chk("idle_valid_insert", 64'(valid_insert), 64'(0));
                chk("idle_valid_in", 64'(valid_in), 64'(0));
                chk("idle_s_ready_insert", 64'(s_ready_insert), 64'(0));
                chk("idle_s_ready_in", 64'(s_ready_in), 64'(0));
                chk("idle_header_insert", 64'(header_insert), 64'(0));
                chk("idle_data_in", 64'(data_in), 64'(0));
                if (s_valid_insert != '0) begin
                    cur_src   = rr_pick(last_grant, s_valid_insert);
                    in_data   = 1'b0;
                    hdr_first = 1'b1;
                    cur_beats = 0;
                end
            end else if (!in_data) begin
                g  = IDW'(cur_src);
                ev = '0;
                ev[g] = ready_insert;
                if (hdr_first) grant_log.push_back(int'(grant_id));
                hdr_first = 1'b0;
                chk("hdr_grant_id", 64'(grant_id), 64'(g));
                chk("hdr_valid_insert", 64'(valid_insert), 64'(s_valid_insert[g]));
                chk("hdr_s_ready_insert", 64'(s_ready_insert), 64'(ev));
                chk("hdr_s_ready_in", 64'(s_ready_in), 64'(0));
                chk("hdr_valid_in", 64'(valid_in), 64'(0));
                chk("hdr_data_in", 64'(data_in), 64'(0));
                chk("hdr_header_mux", 64'(header_insert), 64'(s_header_insert[cur_src*DW +: DW]));
                if (s_valid_insert[g]) begin
                    if (exp_hdr[cur_src].size() == 0) begin
                        n_checks++; n_err++;
                        $display("FAIL hdr_sb: header %0h presented, expected none queued", header_insert);
                    end else begin
                        eh = exp_hdr[cur_src][0];
                        chk("hdr_value", 64'(header_insert), 64'(eh.h));
                        chk("hdr_keep", 64'(keep_insert), 64'(eh.k));
                        if (ready_insert) begin
                            eh = exp_hdr[cur_src].pop_front();
                            in_data = 1'b1;
                        end
                    end
                end
            end else begin
                g  = IDW'(cur_src);
                ev = '0;
                ev[g] = ready_in;
                chk("dat_grant_id", 64'(grant_id), 64'(g));
                chk("dat_valid_in", 64'(valid_in), 64'(s_valid_in[g]));
                chk("dat_s_ready_in", 64'(s_ready_in), 64'(ev));
                chk("dat_s_ready_insert", 64'(s_ready_insert), 64'(0));
                chk("dat_valid_insert", 64'(valid_insert), 64'(0));
                chk("dat_header_insert", 64'(header_insert), 64'(0));
                chk("dat_data_mux", 64'(data_in), 64'(s_data_in[cur_src*DW +: DW]));
                if (s_valid_in[g]) begin
                    if (exp_beat[cur_src].size() == 0) begin
                        n_checks++; n_err++;
                        $display("FAIL dat_sb: beat %0h presented, expected none queued", data_in);
                        cur_src = -1;
                    end else begin
                        eb = exp_beat[cur_src][0];
                        chk("dat_value", 64'(data_in), 64'(eb.d));
                        chk("dat_keep", 64'(keep_in), 64'(eb.k));
                        chk("dat_last", 64'(last_in), 64'(eb.l));
                        if (ready_in) begin
                            eb = exp_beat[cur_src].pop_front();
                            cur_beats++;
                            total_beats++;
                            if (eb.l) begin
                                last_grant = cur_src;
                                mdl_cnt    = mdl_cnt + 16'd1;
                                cur_src    = -1;
                                in_data    = 1'b0;
                            end
                        end
                    end
                end
            end
        end
    end

    function automatic bit all_drained();
        for (int i = 0; i < NSRC; i++) begin
            if (src_hdr[i].size() != 0 || src_beat[i].size() != 0) return 1'b0;
        end
        return (cur_src < 0);
    endfunction

    task automatic wait_drain(input string nm, input int budget);
        int c;
        c = 0;
        while (!all_drained() && c < budget) begin
            @(posedge clk);
            c++;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (c >= budget) begin
            n_err++;
            $display("FAIL %s: traffic still pending after %0d cycles, expected drained", nm, budget);
        end
    endtask

    task automatic chk_order(input string nm, input int base, input int n, input int exp_o[4]);
        for (int k = 0; k < n; k++) begin
            if (base + k < grant_log.size()) begin
                chk(nm, 64'(grant_log[base + k]), 64'(exp_o[k]));
            end else begin
                n_checks++; n_err++;
                $display("FAIL %s: grant %0d never seen, expected source %0d", nm, k, exp_o[k]);
            end
        end
    endtask

    task automatic do_reset();
        rst_req_cnt++;
        repeat (3) @(posedge clk);
    endtask

    initial begin : main
        int base;
        int c;
        repeat (5) @(posedge clk);

        // single source, 5 beats, ready_in stalled 3 cycles after the second beat
        base = grant_log.size();
        issue_pkt(2, 32'hA5A5_0001, 4'b0111, 5);
        c = 0;
        while (total_beats < 2 && c < 200) begin @(posedge clk); c++; end
        bp_req_cnt++;
        wait_drain("single_src", 500);
        chk("single_pkt_cnt", 64'(pkt_cnt), 64'(1));
        chk_order("single_grant", base, 1, '{2, 0, 0, 0});

        // fairness: after source 2, sources 0 and 3 together -> 3 then 0
        base = grant_log.size();
        issue_pkt(0, $urandom, KW'($urandom), 3);
        issue_pkt(3, $urandom, KW'($urandom), 2);
        wait_drain("fairness", 500);
        chk_order("fair_grant", base, 2, '{3, 0, 0, 0});
        chk("fair_pkt_cnt", 64'(pkt_cnt), 64'(3));

        // all four after reset -> 0,1,2,3
        do_reset();
        base = grant_log.size();
        for (int s = 0; s < NSRC; s++) issue_pkt(s, $urandom, KW'($urandom), 1 + s);
        wait_drain("all_four", 1000);
        chk_order("all4_grant", base, 4, '{0, 1, 2, 3});
        chk("all4_pkt_cnt", 64'(pkt_cnt), 64'(4));

        // randomized traffic with random backpressure on both engine ports
        rdy_pct = 60;
        for (int n = 0; n < 300; n++) begin
            int s;
            s = $urandom_range(0, NSRC - 1);
            if (($urandom % 3) == 0 && src_hdr[s].size() < 3)
                issue_pkt(s, $urandom, KW'($urandom), $urandom_range(1, 6));
            @(posedge clk);
        end
        wait_drain("random", 20000);

        // reset in the middle of a payload
        rdy_pct = 100;
        issue_pkt(1, $urandom, KW'($urandom), 5);
        c = 0;
        while (!(cur_src >= 0 && in_data && cur_beats == 2) && c < 200) begin
            @(posedge clk);
            c++;
        end
        n_checks++;
        if (c >= 200) begin
            n_err++;
            $display("FAIL mid_rst_setup: did not reach beat 3 of packet, waited %0d cycles", c);
        end
        rst_req_cnt++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_valid_insert", 64'(valid_insert), 64'(0));
        chk("rst_valid_in", 64'(valid_in), 64'(0));
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'(0));
        base = grant_log.size();
        for (int s = NSRC - 1; s >= 0; s--) issue_pkt(s, $urandom, KW'($urandom), 2);
        wait_drain("after_rst", 1000);
        chk_order("after_rst_grant", base, 1, '{0, 0, 0, 0});
        chk("after_rst_pkt_cnt", 64'(pkt_cnt), 64'(4));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
